// File: rtl/parser_seq_ctrl.sv
`timescale 1ns/1ps
// parser_seq_ctrl: per-frame sequencer that gates the ethernet/IPv4/IPv6 header parsers,
// stalls the stream for the metadata handshake, and drops runt/unsupported/stalled frames.
module parser_seq_ctrl #(
  parameter int DATA_W      = 64,
  parameter int IPV4_XTRA   = 3,
  parameter int IPV6_XTRA   = 5,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic              s_axis_tvalid,
  input  logic              s_axis_tlast,
  output logic              s_axis_tready,
  output logic              eth_en,
  output logic              ipv4_en,
  output logic              ipv6_en,
  output logic              meta_valid,
  input  logic              meta_ready,
  output logic [1:0]        meta_proto,
  output logic              meta_done,
  output logic              err_runt,
  output logic              err_timeout,
  output logic [31:0]       pkt_cnt,
  output logic [15:0]       drop_cnt
);

  localparam int XTRA_MAX = (IPV4_XTRA > IPV6_XTRA) ? IPV4_XTRA : IPV6_XTRA;
  localparam int BW       = $clog2(XTRA_MAX + 1);
  localparam int IW       = $clog2(TIMEOUT_CYC);
  localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT_CYC - 1);

  if (DATA_W != 64) begin : g_bad_width
    $fatal(1, "parser_seq_ctrl supports DATA_W=64 only");
  end

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ETH1    = 3'd1,
    S_IP      = 3'd2,
    S_META    = 3'd3,
    S_PAYLOAD = 3'd4,
    S_DROP    = 3'd5
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [BW-1:0]   r_beat_cnt;
  logic [BW-1:0]   w_beat_cnt_nxt;
  logic [IW-1:0]   r_idle_cnt;
  logic [1:0]      r_proto;
  logic [1:0]      w_proto_nxt;
  logic            r_last_seen;
  logic            w_last_seen_nxt;
  logic [31:0]     r_pkt_cnt;
  logic [15:0]     r_drop_cnt;
  logic            w_drop_inc;
  logic            w_pkt_inc;
  logic            w_accept;
  logic            w_count_state;
  logic            w_idle_last;
  logic [15:0]     w_etype;
  logic            w_is_v4;
  logic            w_is_v6;
  logic            w_unused_data;

  // Ethertype sits in bytes 4..5 of the second beat; byte 0 is the MSB lane.
  assign w_etype       = s_axis_tdata[31:16];
  assign w_unused_data = ^{s_axis_tdata[DATA_W-1:32], s_axis_tdata[15:0]};
  assign w_is_v4       = (w_etype == 16'h0800);
  assign w_is_v6       = (w_etype == 16'h86DD);

  assign s_axis_tready = (r_state != S_META);
  assign w_accept      = s_axis_tvalid & s_axis_tready;
  assign w_count_state = (r_state == S_ETH1) || (r_state == S_IP) ||
                         (r_state == S_PAYLOAD) || (r_state == S_DROP);
  assign w_idle_last   = (r_idle_cnt == IDLE_LAST);

  assign pkt_cnt  = r_pkt_cnt;
  assign drop_cnt = r_drop_cnt;

  always_comb begin
    w_state_nxt     = r_state;
    w_beat_cnt_nxt  = r_beat_cnt;
    w_proto_nxt     = r_proto;
    w_last_seen_nxt = r_last_seen;
    w_drop_inc      = 1'b0;
    w_pkt_inc       = 1'b0;
    eth_en          = 1'b0;
    ipv4_en         = 1'b0;
    ipv6_en         = 1'b0;
    meta_valid      = 1'b0;
    meta_proto      = 2'b00;
    meta_done       = 1'b0;
    err_runt        = 1'b0;
    err_timeout     = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          eth_en = 1'b1;
          if (s_axis_tlast) begin
            err_runt   = 1'b1;
            w_drop_inc = 1'b1;
          end else begin
            w_state_nxt = S_ETH1;
          end
        end
      end
      S_ETH1: begin
        if (w_accept) begin
          eth_en = 1'b1;
          if (w_is_v4) begin
            ipv4_en        = 1'b1;
            w_beat_cnt_nxt = BW'(IPV4_XTRA);
            w_proto_nxt    = 2'b01;
          end else if (w_is_v6) begin
            ipv6_en        = 1'b1;
            w_beat_cnt_nxt = BW'(IPV6_XTRA);
            w_proto_nxt    = 2'b10;
          end
          if (s_axis_tlast) begin
            err_runt    = 1'b1;
            w_drop_inc  = 1'b1;
            w_state_nxt = S_IDLE;
          end else if (w_is_v4 || w_is_v6) begin
            w_state_nxt = S_IP;
          end else begin
            w_drop_inc  = 1'b1;
            w_state_nxt = S_DROP;
          end
        end
      end
      S_IP: begin
        if (w_accept) begin
          ipv4_en        = (r_proto == 2'b01);
          ipv6_en        = (r_proto == 2'b10);
          w_beat_cnt_nxt = r_beat_cnt - BW'(1);
          if (r_beat_cnt == BW'(1)) begin
            w_state_nxt     = S_META;
            w_last_seen_nxt = s_axis_tlast;
          end else if (s_axis_tlast) begin
            err_runt    = 1'b1;
            w_drop_inc  = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end
      end
      S_META: begin
        meta_valid = 1'b1;
        meta_proto = r_proto;
        if (meta_ready) begin
          meta_done   = 1'b1;
          w_pkt_inc   = 1'b1;
          w_state_nxt = r_last_seen ? S_IDLE : S_PAYLOAD;
        end
      end
      S_PAYLOAD, S_DROP: begin
        if (w_accept && s_axis_tlast) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // Stalled frame: drop is only counted if nothing has accounted for this frame yet.
    if (w_count_state && !w_accept && w_idle_last) begin
      err_timeout = 1'b1;
      w_state_nxt = S_IDLE;
      if ((r_state == S_ETH1) || (r_state == S_IP)) w_drop_inc = 1'b1;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state     <= S_IDLE;
      r_beat_cnt  <= '0;
      r_idle_cnt  <= '0;
      r_proto     <= 2'b00;
      r_last_seen <= 1'b0;
      r_pkt_cnt   <= '0;
      r_drop_cnt  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_beat_cnt  <= w_beat_cnt_nxt;
      r_proto     <= w_proto_nxt;
      r_last_seen <= w_last_seen_nxt;
      if (w_count_state && !w_accept && (w_state_nxt == r_state))
        r_idle_cnt <= r_idle_cnt + IW'(1);
      else
        r_idle_cnt <= '0;
      if (w_pkt_inc) r_pkt_cnt <= r_pkt_cnt + 32'd1;
      if (w_drop_inc && (r_drop_cnt != 16'hFFFF)) r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_parser_seq_ctrl.sv
`timescale 1ns/1ps
// Bench for parser_seq_ctrl: directed vector table, multi-cycle corner sequences,
// then random frames checked against a beat-index reference model.
module tb_parser_seq_ctrl;

  localparam int V4X = 3;
  localparam int V6X = 5;
  localparam int TO  = 1024;

  // {tready, eth_en, ipv4_en, ipv6_en, meta_valid, meta_proto[1:0], meta_done, err_runt, err_timeout}
  localparam logic [9:0] O_IDLE   = 10'b1_0_0_0_0_00_0_0_0;
  localparam logic [9:0] O_ETH    = 10'b1_1_0_0_0_00_0_0_0;
  localparam logic [9:0] O_ETH4   = 10'b1_1_1_0_0_00_0_0_0;
  localparam logic [9:0] O_ETH6   = 10'b1_1_0_1_0_00_0_0_0;
  localparam logic [9:0] O_V4     = 10'b1_0_1_0_0_00_0_0_0;
  localparam logic [9:0] O_V6     = 10'b1_0_0_1_0_00_0_0_0;
  localparam logic [9:0] O_META4  = 10'b0_0_0_0_1_01_0_0_0;
  localparam logic [9:0] O_META4D = 10'b0_0_0_0_1_01_1_0_0;
  localparam logic [9:0] O_META6  = 10'b0_0_0_0_1_10_0_0_0;
  localparam logic [9:0] O_META6D = 10'b0_0_0_0_1_10_1_0_0;
  localparam logic [9:0] O_RUNT0  = 10'b1_1_0_0_0_00_0_1_0;
  localparam logic [9:0] O_RUNT4  = 10'b1_0_1_0_0_00_0_1_0;
  localparam logic [9:0] O_TMO    = 10'b1_0_0_0_0_00_0_0_1;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic [63:0] s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tlast;
  logic        s_axis_tready;
  logic        eth_en, ipv4_en, ipv6_en;
  logic        meta_valid, meta_ready, meta_done;
  logic [1:0]  meta_proto;
  logic        err_runt, err_timeout;
  logic [31:0] pkt_cnt;
  logic [15:0] drop_cnt;

  int n_chk = 0;
  int n_err = 0;

  parser_seq_ctrl #(
    .DATA_W(64), .IPV4_XTRA(V4X), .IPV6_XTRA(V6X), .TIMEOUT_CYC(TO)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
    .eth_en(eth_en), .ipv4_en(ipv4_en), .ipv6_en(ipv6_en),
    .meta_valid(meta_valid), .meta_ready(meta_ready), .meta_proto(meta_proto),
    .meta_done(meta_done), .err_runt(err_runt), .err_timeout(err_timeout),
    .pkt_cnt(pkt_cnt), .drop_cnt(drop_cnt)
  );

  always #5 aclk = ~aclk;

  wire [9:0] w_outs = {s_axis_tready, eth_en, ipv4_en, ipv6_en, meta_valid,
                       meta_proto, meta_done, err_runt, err_timeout};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic l, input logic [63:0] d, input logic mr);
    @(negedge aclk);
    s_axis_tvalid = v;
    s_axis_tlast  = l;
    s_axis_tdata  = d;
    meta_ready    = mr;
    #1;
  endtask

  function automatic logic [63:0] mkd(input logic [15:0] et);
    logic [63:0] d;
    d = {$urandom, $urandom};
    d[31:16] = et;
    return d;
  endfunction

  function automatic logic [63:0] tbl_data(input logic [1:0] ds);
    case (ds)
      2'd1:    return mkd(16'h0800);
      2'd2:    return mkd(16'h86DD);
      2'd3:    return mkd(16'h0806);
      default: return {$urandom, $urandom};
    endcase
  endfunction

  // ---------------- reference model (frame position, not FSM states) ----------------
  int          m_k;      // beats accepted so far in the current frame
  int          m_kind;   // 1 IPv4, 2 IPv6, 3 unsupported
  bit          m_wait, m_last, m_done, m_drp;
  int          m_idle;
  logic [31:0] m_pkt;
  int          m_drop;

  function automatic void m_end();
    m_k = 0; m_kind = 0; m_wait = 0; m_last = 0; m_done = 0; m_drp = 0;
  endfunction

  function automatic void m_dropinc();
    if (m_drop < 65535) m_drop++;
  endfunction

  task automatic model_step(input logic v, input logic l, input logic [63:0] d,
                            input logic mr, output logic [9:0] eo);
    logic trdy, eth, e4, e6, mv, md, runt, tmo;
    logic [1:0] pr;
    int hdr_last;
    eth = 0; e4 = 0; e6 = 0; mv = 0; md = 0; runt = 0; tmo = 0; pr = 2'b00;
    trdy = !m_wait;
    if (m_wait) begin
      mv = 1;
      pr = 2'(m_kind);
      if (mr) begin
        md = 1;
        m_pkt++;
        m_idle = 0;
        if (m_last) m_end();
        else begin m_wait = 0; m_done = 1; end
      end
    end else if (v) begin
      m_idle = 0;
      if (m_k == 0) begin
        eth = 1;
        if (l) begin runt = 1; m_dropinc(); end
        else m_k = 1;
      end else if (m_k == 1) begin
        eth = 1;
        if (d[31:16] == 16'h0800) begin m_kind = 1; e4 = 1; end
        else if (d[31:16] == 16'h86DD) begin m_kind = 2; e6 = 1; end
        else m_kind = 3;
        if (l) begin runt = 1; m_dropinc(); m_end(); end
        else begin
          m_k = 2;
          if (m_kind == 3) begin m_dropinc(); m_drp = 1; end
        end
      end else if (m_drp || m_done) begin
        if (l) m_end();
        else m_k++;
      end else begin
        e4 = (m_kind == 1);
        e6 = (m_kind == 2);
        hdr_last = 1 + ((m_kind == 1) ? V4X : V6X);
        if (m_k == hdr_last) begin m_wait = 1; m_last = l; m_k++; end
        else if (l) begin runt = 1; m_dropinc(); m_end(); end
        else m_k++;
      end
    end else if (m_k >= 1) begin
      if (m_idle == TO - 1) begin
        tmo = 1;
        if (!m_drp && !m_done) m_dropinc();
        m_end();
        m_idle = 0;
      end else m_idle++;
    end else m_idle = 0;
    eo = {trdy, eth, e4, e6, mv, pr, md, runt, tmo};
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic       v;
    logic       l;
    logic [1:0] ds;
    logic       mr;
    logic [9:0] eo;
    int         pkt;
    int         drp;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic v, input logic l, input logic [1:0] ds, input logic mr,
                     input logic [9:0] eo, input int pkt, input int drp);
    vec_t r;
    r.v = v; r.l = l; r.ds = ds; r.mr = mr; r.eo = eo; r.pkt = pkt; r.drp = drp;
    tbl.push_back(r);
  endtask

  task automatic add_ipv4_frame(input int pkt0, input int drp0);
    add(1, 0, 0, 1, O_ETH,    pkt0,     drp0);
    add(1, 0, 1, 1, O_ETH4,   pkt0,     drp0);
    add(1, 0, 0, 1, O_V4,     pkt0,     drp0);
    add(1, 0, 0, 1, O_V4,     pkt0,     drp0);
    add(1, 0, 0, 1, O_V4,     pkt0,     drp0);
    add(1, 0, 0, 1, O_META4D, pkt0,     drp0);
    add(1, 0, 0, 1, O_IDLE,   pkt0 + 1, drp0);
    add(1, 1, 0, 1, O_IDLE,   pkt0 + 1, drp0);
  endtask

  logic [63:0] q_d[$];
  logic        q_l[$];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, n_chk=%0d", n_chk);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0]  eo;
    logic [31:0] ep;
    int          ed;
    int          bi;
    int          guard;
    logic        v, l, mr;
    logic [63:0] d;

    aresetn = 1'b0;
    s_axis_tvalid = 0; s_axis_tlast = 0; s_axis_tdata = '0; meta_ready = 0;
    @(negedge aclk); @(negedge aclk); #1;
    chk("reset_outs", w_outs, O_IDLE);
    chk("reset_pkt",  pkt_cnt, 0);
    chk("reset_drop", drop_cnt, 0);
    aresetn = 1'b1;

    // IPv4 frame, ARP drop, IPv4 runt at beat 3, then IPv4 again back-to-back.
    add_ipv4_frame(0, 0);
    add(1, 0, 0, 1, O_ETH,   1, 0);
    add(1, 0, 3, 1, O_ETH,   1, 0);
    add(1, 0, 0, 1, O_IDLE,  1, 1);
    add(1, 1, 0, 1, O_IDLE,  1, 1);
    add(0, 0, 0, 1, O_IDLE,  1, 1);
    add(1, 0, 0, 1, O_ETH,   1, 1);
    add(1, 0, 1, 1, O_ETH4,  1, 1);
    add(1, 0, 0, 1, O_V4,    1, 1);
    add(1, 1, 0, 1, O_RUNT4, 1, 1);
    add_ipv4_frame(1, 2);
    add(0, 0, 0, 0, O_IDLE,  2, 2);

    foreach (tbl[i]) begin
      drive(tbl[i].v, tbl[i].l, tbl_data(tbl[i].ds), tbl[i].mr);
      chk($sformatf("tbl%0d_outs", i), w_outs,   tbl[i].eo);
      chk($sformatf("tbl%0d_pkt",  i), pkt_cnt,  tbl[i].pkt);
      chk($sformatf("tbl%0d_drop", i), drop_cnt, tbl[i].drp);
    end

    // IPv6 header with meta_ready held low for 10 cycles.
    drive(1, 0, mkd(16'h1234), 0); chk("v6_b0", w_outs, O_ETH);
    drive(1, 0, mkd(16'h86DD), 0); chk("v6_b1", w_outs, O_ETH6);
    for (int i = 2; i <= 6; i++) begin
      drive(1, 0, mkd(16'h0000), 0);
      chk($sformatf("v6_b%0d", i), w_outs, O_V6);
    end
    d = mkd(16'hBEEF);
    for (int i = 0; i < 10; i++) begin
      drive(1, 0, d, 0);
      chk($sformatf("v6_stall%0d", i), w_outs, O_META6);
    end
    drive(1, 0, d, 1);   chk("v6_done", w_outs, O_META6D); chk("v6_pkt_before", pkt_cnt, 2);
    drive(1, 1, d, 0);   chk("v6_payload", w_outs, O_IDLE); chk("v6_pkt_after", pkt_cnt, 3);
    drive(0, 0, '0, 0);  chk("v6_idle", w_outs, O_IDLE);

    // Stall mid-IPv4 header until timeout; the next beat must start a new frame.
    drive(1, 0, mkd(16'h0000), 0); chk("tmo_b0", w_outs, O_ETH);
    drive(1, 0, mkd(16'h0800), 0); chk("tmo_b1", w_outs, O_ETH4);
    drive(1, 0, mkd(16'h0000), 0); chk("tmo_b2", w_outs, O_V4);
    for (int i = 1; i <= TO; i++) begin
      drive(0, 0, '0, 0);
      chk($sformatf("tmo_idle%0d", i), w_outs, (i == TO) ? O_TMO : O_IDLE);
    end
    drive(1, 1, mkd(16'h0000), 0);
    chk("tmo_newframe", w_outs, O_RUNT0);
    chk("tmo_drop", drop_cnt, 3);
    drive(0, 0, '0, 0);
    chk("tmo_runt_drop", drop_cnt, 4);

    // Reset while waiting in the metadata stall.
    drive(1, 0, mkd(16'h0000), 0);
    drive(1, 0, mkd(16'h0800), 0);
    for (int i = 0; i < V4X; i++) drive(1, 0, mkd(16'h0000), 0);
    drive(0, 0, '0, 0);
    chk("rst_pre_meta", w_outs, O_META4);
    chk("rst_pre_pkt", pkt_cnt, 3);
    aresetn = 1'b0;
    #1;
    chk("rst_async_outs", w_outs, O_IDLE);
    chk("rst_async_pkt", pkt_cnt, 0);
    chk("rst_async_drop", drop_cnt, 0);
    drive(0, 0, '0, 1);
    aresetn = 1'b1;
    drive(0, 0, '0, 1);
    chk("rst_release_outs", w_outs, O_IDLE);

    // Random frames against the reference model.
    m_end(); m_idle = 0; m_pkt = 0; m_drop = 0;
    for (int f = 0; f < 250; f++) begin
      int   kind, len;
      logic [15:0] et;
      kind = $urandom_range(0, 2);
      len  = $urandom_range(1, 12);
      et   = (kind == 0) ? 16'h0800 : (kind == 1) ? 16'h86DD : 16'($urandom);
      if (kind == 2 && (et == 16'h0800 || et == 16'h86DD)) et = 16'h0806;
      for (int j = 0; j < len; j++) begin
        q_d.push_back((j == 1) ? mkd(et) : {$urandom, $urandom});
        q_l.push_back(j == len - 1);
      end
    end
    bi = 0;
    guard = 0;
    while ((bi < q_d.size() || m_wait || m_k != 0) && guard < 30000) begin
      v  = (bi < q_d.size()) && ($urandom_range(0, 3) != 0);
      d  = v ? q_d[bi] : {$urandom, $urandom};
      l  = v ? q_l[bi] : 1'($urandom_range(0, 1));
      mr = ($urandom_range(0, 2) != 0);
      drive(v, l, d, mr);
      ep = m_pkt;
      ed = m_drop;
      model_step(v, l, d, mr, eo);
      chk("rand_outs", w_outs, eo);
      chk("rand_pkt", pkt_cnt, ep);
      chk("rand_drop", drop_cnt, ed);
      if (v && eo[9]) bi++;
      guard++;
    end
    chk("rand_drain_bound", guard < 30000, 1);
    drive(0, 0, '0, 0);
    chk("rand_final_pkt", pkt_cnt, m_pkt);
    chk("rand_final_drop", drop_cnt, m_drop);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
